// File: rtl/shared_cnt_arb_pkg.sv
// rtl/shared_cnt_arb_pkg.sv - shared types for the shared-counter arbiter
package shared_cnt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select
// Scans last+1, last+2, ... mod NUM_REQ and returns the first requester found.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;

  always_comb begin
    // rot[k] is the requester k+1 positions after last; a shift of NUM_REQ is a full turn
    rot    = NUM_REQ'({req, req} >> (int'(last) + 1));
    winner = last;
    any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        winner = IDX_W'((int'(last) + 1 + k) % NUM_REQ);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_cnt_arbiter.sv
// rtl/shared_cnt_arbiter.sv - round-robin arbiter guarding one shared up-counter
// Only the granted requester may bump the counter; grants are bounded by MAX_HOLD cycles.
module shared_cnt_arbiter
  import shared_cnt_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] inc,
  output logic [NUM_REQ-1:0] gnt,
  output logic [CNT_W-1:0]   cnt,
  output logic               cnt_even,
  output logic               wrap,
  output logic               preempt
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   last, last_nxt, winner;
  logic [HOLD_W-1:0]  hold, hold_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               preempt_nxt;
  logic               any;
  logic               cnt_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      hold    <= '0;
      last    <= IDX_W'(NUM_REQ - 1);
      preempt <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      hold    <= hold_nxt;
      last    <= last_nxt;
      preempt <= preempt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    hold_nxt    = hold;
    last_nxt    = last;
    preempt_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_nxt = BUSY;
          gnt_nxt   = NUM_REQ'(1) << winner;
          hold_nxt  = HOLD_W'(1);
          last_nxt  = winner;
        end
      end
      BUSY: begin
        // last always names the current holder while BUSY
        if (!req[last]) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
        end else if (hold == HOLD_W'(MAX_HOLD)) begin
          state_nxt   = GAP;
          gnt_nxt     = '0;
          preempt_nxt = 1'b1;
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      GAP: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // the grant registered for this cycle gates the strobe, so the final grant cycle still counts
  assign cnt_hit = |(inc & gnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= cnt_hit && (cnt == {CNT_W{1'b1}});
      if (cnt_hit) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign cnt_even = ~cnt[0];

  a_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(gnt))
    else $error("a_onehot: gnt=%b", gnt);

  a_hold: assert property (@(posedge clk) disable iff (!reset)
    (gnt != '0) |-> (hold <= HOLD_W'(MAX_HOLD)))
    else $error("a_hold: hold=%0d", hold);

  a_noinc: assert property (@(posedge clk) disable iff (!reset)
    !cnt_hit |=> $stable(cnt))
    else $error("a_noinc: cnt=%0d", cnt);

  a_inc: assert property (@(posedge clk) disable iff (!reset)
    cnt_hit |=> (cnt == $past(cnt) + CNT_W'(1)))
    else $error("a_inc: cnt=%0d", cnt);

  a_gap: assert property (@(posedge clk) disable iff (!reset)
    $fell(|gnt) |=> (gnt == '0))
    else $error("a_gap: gnt=%b", gnt);

endmodule

// File: tb/tb_shared_cnt_arbiter.sv
// tb/tb_shared_cnt_arbiter.sv - scoreboard bench for shared_cnt_arbiter
module tb_shared_cnt_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int CNT_W    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       req   = '0;
  logic [3:0]       inc   = '0;
  logic [3:0]       gnt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_even;
  logic             wrap;
  logic             preempt;

  always #5 clk = ~clk;

  shared_cnt_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CNT_W    (CNT_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .inc      (inc),
    .gnt      (gnt),
    .cnt      (cnt),
    .cnt_even (cnt_even),
    .wrap     (wrap),
    .preempt  (preempt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: 0 IDLE, 1 BUSY, 2 GAP
  int         m_state;
  int         m_hold;
  logic [1:0] m_last;
  logic [3:0] m_gnt;
  logic [7:0] m_cnt;
  logic       m_wrap;
  logic       m_pre;

  task automatic model_reset();
    m_state = 0;
    m_hold  = 0;
    m_last  = 2'd3;
    m_gnt   = '0;
    m_cnt   = '0;
    m_wrap  = 1'b0;
    m_pre   = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] i);
    int w;
    int c;
    if (!reset) begin
      model_reset();
      return;
    end
    m_wrap = 1'b0;
    if ((i & m_gnt) != 4'b0) begin
      m_wrap = (m_cnt == 8'hFF);
      m_cnt  = m_cnt + 8'd1;
    end
    m_pre = 1'b0;
    case (m_state)
      0: begin
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (int'(m_last) + k) % NUM_REQ;
          if (w < 0 && r[c[1:0]]) w = c;
        end
        if (w >= 0) begin
          m_state = 1;
          m_last  = w[1:0];
          m_gnt   = 4'b0001 << w;
          m_hold  = 1;
        end
      end
      1: begin
        if (!r[m_last]) begin
          m_state = 2;
          m_gnt   = '0;
        end else if (m_hold == MAX_HOLD) begin
          m_state = 2;
          m_gnt   = '0;
          m_pre   = 1'b1;
        end else begin
          m_hold = m_hold + 1;
        end
      end
      default: begin
        m_state = 0;
        m_gnt   = '0;
      end
    endcase
  endtask

  function automatic logic [31:0] exp_vec();
    return {17'b0, m_gnt, m_cnt, m_wrap, m_pre, ~m_cnt[0]};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {17'b0, gnt, cnt, wrap, preempt, cnt_even};
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  logic [31:0] sb_q[$];

  task automatic cycle(input logic [3:0] r, input logic [3:0] i);
    req = r;
    inc = i;
    model_step(r, i);
    sb_q.push_back(exp_vec());
    @(negedge clk);
    check("cycle", obs_vec(), sb_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    cycle(4'h0, 4'h0);
    reset = 1'b1;
  endtask

  int         gexp[$];
  int         k_grant;
  int         n_pre;
  int         wrap_cyc;
  logic [3:0] prev_g;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 reset = 1'b0;
    @(negedge clk);

    // T1: reset held with all requests pending
    repeat (3) cycle(4'hF, 4'h0);
    check("t1_gnt", gnt, 32'h0);
    check("t1_cnt", cnt, 32'h0);
    check("t1_even", cnt_even, 32'h1);
    reset = 1'b1;

    // T2: single requester, early voluntary release
    cycle(4'b0100, 4'b0100);
    check("t2_gnt", gnt, 32'h4);
    cycle(4'b0100, 4'b0100);
    cycle(4'b0100, 4'b0100);
    check("t2_cnt", cnt, 32'd2);
    cycle(4'b0000, 4'b0000);
    check("t2_gap", gnt, 32'h0);
    cycle(4'b0000, 4'b0000);

    // T3: full contention, every grant preempted after MAX_HOLD
    do_reset();
    gexp    = '{0, 1, 2, 3, 0};
    k_grant = 0;
    n_pre   = 0;
    prev_g  = '0;
    for (int c = 0; c < 30; c++) begin
      cycle(4'hF, 4'hF);
      if (preempt) n_pre++;
      if (gnt != 4'b0 && prev_g == 4'b0) begin
        if (gexp.size() > 0) check("t3_order", onehot_idx(gnt), gexp.pop_front());
        check("t3_cnt", cnt, 4 * k_grant);
        k_grant++;
      end
      prev_g = gnt;
    end
    check("t3_grants", k_grant, 5);
    check("t3_preempts", n_pre, 5);
    cycle(4'h0, 4'h0);
    cycle(4'h0, 4'h0);

    // T4: strobes from non-granted requesters are ignored
    cycle(4'b0001, 4'b1110);
    check("t4_gnt", gnt, 32'h1);
    repeat (4) cycle(4'b0001, 4'b1110);
    check("t4_cnt", cnt, 32'd20);
    cycle(4'h0, 4'h0);
    cycle(4'h0, 4'h0);

    // T5: counter wrap from all-ones
    do_reset();
    wrap_cyc = -1;
    for (int c = 0; c < 500; c++) begin
      cycle(4'hF, 4'hF);
      if (m_wrap) begin
        check("t5_wrap", wrap, 32'h1);
        check("t5_cnt", cnt, 32'h0);
        wrap_cyc = c + 1;
        break;
      end
    end
    check("t5_wrap_edge", wrap_cyc, 383);
    cycle(4'hF, 4'hF);
    check("t5_wrap_pulse", wrap, 32'h0);

    // T6: reset during an active grant
    do_reset();
    repeat (10) cycle(4'b0001, 4'b0001);
    check("t6_pre_cnt", cnt, 32'd7);
    check("t6_pre_gnt", gnt, 32'h1);
    reset = 1'b0;
    #1;
    check("t6_gnt", gnt, 32'h0);
    check("t6_cnt", cnt, 32'h0);
    model_reset();
    cycle(4'b0001, 4'b0001);
    reset = 1'b1;
    cycle(4'hF, 4'h0);
    check("t6_first", gnt, 32'h1);
    cycle(4'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
